// File: rtl/vsm_drain.sv
// vsm_drain: captures one SIZE-byte result vector from the vsm output bus and
// replays it one byte per valid/ready handshake, element 0 (LSB byte) first.
module vsm_drain #(
    parameter  int SIZE = 6,
    localparam int IW   = $clog2(SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [8*SIZE-1:0] in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [IW-1:0]     out_index,
    output logic              out_last,
    output logic              busy
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

    state_t            state, state_n;
    logic [8*SIZE-1:0] buffer;
    logic [IW-1:0]     idx, idx_n;
    logic              load;
    logic              at_last;
    logic              in_xfer;
    logic              out_xfer;

    assign at_last   = (idx == LAST_IDX);
    assign busy      = (state == SEND);
    assign out_valid = busy;
    assign out_index = busy ? idx : '0;
    assign out_last  = busy & at_last;
    assign out_data  = busy ? buffer[8*idx +: 8] : 8'h00;

    // Depends on out_ready combinationally so the next vector is taken on the
    // last beat of the current one and the stream never bubbles.
    assign in_ready = (state == IDLE) | (busy & at_last & out_ready & ~flush);
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        state_n = state;
        idx_n   = idx;
        load    = 1'b0;
        if (flush) begin
            state_n = IDLE;
            idx_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_xfer) begin
                        load    = 1'b1;
                        idx_n   = '0;
                        state_n = SEND;
                    end
                end
                SEND: begin
                    if (out_xfer) begin
                        if (!at_last) begin
                            idx_n = idx + IW'(1);
                        end else if (in_xfer) begin
                            load  = 1'b1;
                            idx_n = '0;
                        end else begin
                            state_n = IDLE;
                            idx_n   = '0;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            idx    <= '0;
            // NOTE: the vector buffer is a plain register bank, so it is cleared on reset like any flop.
            buffer <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (load) begin
                buffer <= in_vec;
            end
        end
    end

endmodule

// File: tb/tb_vsm_drain.sv
// Self-checking bench for vsm_drain: a queue of pending bytes predicts every
// output each cycle; scenario tasks add explicit checks on the byte streams.
module tb_vsm_drain;

    localparam int SIZE = 6;
    localparam int IW   = $clog2(SIZE);

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [8*SIZE-1:0] in_vec;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic [IW-1:0]     out_index;
    logic              out_last;
    logic              busy;

    typedef struct packed {
        logic          valid;
        logic [7:0]    data;
        logic [IW-1:0] index;
        logic          last;
        logic          busy;
        logic          in_ready;
    } obs_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit accepted;

    byte unsigned mq[$];       // bytes of the held vector still to be sent
    byte unsigned seen[$];     // bytes the DUT actually handed over
    int           seen_cyc[$]; // cycle of each handed-over byte

    vsm_drain #(.SIZE(SIZE)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic obs_t expected();
        obs_t e;
        e = '0;
        e.in_ready = (mq.size() == 0) || (mq.size() == 1 && out_ready && !flush);
        if (mq.size() > 0) begin
            e.valid = 1'b1;
            e.data  = mq[0];
            e.index = IW'(SIZE - mq.size());
            e.last  = (mq.size() == 1);
            e.busy  = 1'b1;
        end
        return e;
    endfunction

    function automatic obs_t observed();
        obs_t o;
        o.valid    = out_valid;
        o.data     = out_data;
        o.index    = out_index;
        o.last     = out_last;
        o.busy     = busy;
        o.in_ready = in_ready;
        return o;
    endfunction

    function automatic bit same(byte unsigned a[$], byte unsigned b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: compare all outputs with the model at the falling edge, then
    // let the model consume the same handshakes the DUT sees at the rising edge.
    task automatic step(input string tag);
        obs_t e, o;
        bit   take_in, take_out;
        @(negedge clk);
        e = expected();
        o = observed();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL %s cyc %0d: observed v=%b d=%h i=%0d l=%b b=%b ir=%b, expected v=%b d=%h i=%0d l=%b b=%b ir=%b",
                     tag, cyc, o.valid, o.data, o.index, o.last, o.busy, o.in_ready,
                     e.valid, e.data, e.index, e.last, e.busy, e.in_ready);
        end
        if (out_valid === 1'b1 && out_ready) begin
            seen.push_back(out_data);
            seen_cyc.push_back(cyc);
        end
        take_in  = in_valid && e.in_ready;
        take_out = (mq.size() > 0) && out_ready;
        @(posedge clk);
        cyc++;
        accepted = 1'b0;
        if (reset) begin
            if (flush) begin
                mq.delete();
            end else begin
                if (take_out) void'(mq.pop_front());
                if (take_in) begin
                    accepted = 1'b1;
                    for (int k = 0; k < SIZE; k++) mq.push_back(in_vec[8*k +: 8]);
                end
            end
        end
        #1;
    endtask

    task automatic clear_log();
        seen.delete();
        seen_cyc.delete();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (mq.size() > 0 && n < 40) begin
            step(tag);
            n++;
        end
        checks++;
        if (mq.size() != 0) begin
            errors++;
            $display("FAIL %s: drain timeout, %0d bytes left, required 0", tag, mq.size());
        end
    endtask

    task automatic send(input logic [8*SIZE-1:0] v, input string tag);
        in_vec   = v;
        in_valid = 1'b1;
        step(tag);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_vec = {SIZE{8'h5A}};
        mq.delete();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (observed() !== obs_t'{1'b0, 8'h00, '0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: observed %h, required v=0 d=00 i=0 l=0 b=0 ir=1", observed());
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        step("reset_idle");
    endtask

    task automatic test_basic_drain();
        byte unsigned want[$];
        want = '{8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        clear_log();
        out_ready = 1'b1;
        send(48'h010203040506, "basic_accept");
        drain("basic");
        step("basic_after");
        checks++;
        if (!same(seen, want)) begin
            errors++;
            $display("FAIL basic_sequence: observed %p, required %p", seen, want);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_idle: observed valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        byte unsigned want[$];
        want = '{8'hF6, 8'hE5, 8'hD4, 8'hC3, 8'hB2, 8'hA1};
        clear_log();
        out_ready = 1'b1;
        send(48'hA1B2C3D4E5F6, "bp_accept");
        for (int n = 0; n < 10 && mq.size() > SIZE - 2; n++) step("bp_pre");
        out_ready = 1'b0;
        repeat (3) begin
            step("bp_stall");
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hD4 || out_index !== IW'(2)) begin
                errors++;
                $display("FAIL bp_hold: observed v=%b d=%h i=%0d, required 1 d4 2", out_valid, out_data, out_index);
            end
        end
        out_ready = 1'b1;
        drain("bp_drain");
        checks++;
        if (!same(seen, want)) begin
            errors++;
            $display("FAIL bp_sequence: observed %p, required %p", seen, want);
        end
    endtask

    task automatic test_back_to_back();
        logic [8*SIZE-1:0] v[2];
        byte unsigned want[$];
        int k = 0;
        int n = 0;
        v[0] = 48'h123456789ABC;
        v[1] = 48'hFEDCBA987654;
        want = '{8'hBC, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12,
                 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};
        clear_log();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_vec    = v[0];
        while ((k < 2 || mq.size() > 0) && n < 40) begin
            step("b2b");
            n++;
            if (accepted) begin
                k++;
                if (k == 2) in_valid = 1'b0;
                else        in_vec = v[k];
            end
        end
        in_valid = 1'b0;
        checks++;
        if (!same(seen, want)) begin
            errors++;
            $display("FAIL b2b_sequence: observed %p, required %p", seen, want);
        end
        checks++;
        if (seen_cyc.size() != 12 || seen_cyc[seen_cyc.size()-1] - seen_cyc[0] != 11) begin
            errors++;
            $display("FAIL b2b_bubble: observed %0d beats over cycles %p, required 12 consecutive",
                     seen_cyc.size(), seen_cyc);
        end
    endtask

    task automatic test_flush();
        byte unsigned want[$];
        want = '{8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        out_ready = 1'b1;
        send(48'h112233445566, "flush_accept");
        for (int n = 0; n < 10 && mq.size() > SIZE - 3; n++) step("flush_pre");
        flush    = 1'b1;
        in_valid = 1'b1;
        in_vec   = 48'h0F0F0F0F0F0F;
        step("flush_cycle");
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_idle: observed v=%b busy=%b ir=%b, required 0 0 1", out_valid, busy, in_ready);
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        step("flush_in_idle");
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_capture: observed valid=%b, required 0", out_valid);
        end
        clear_log();
        send(48'hAABBCCDDEEFF, "flush_new");
        drain("flush_new_drain");
        checks++;
        if (!same(seen, want)) begin
            errors++;
            $display("FAIL flush_sequence: observed %p, required %p", seen, want);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        send({SIZE{8'hFF}}, "arst_accept");
        for (int n = 0; n < 10 && mq.size() > SIZE - 4; n++) step("arst_pre");
        #3 reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_index !== '0 || out_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate: observed v=%b d=%h i=%0d l=%b b=%b, required all 0",
                     out_valid, out_data, out_index, out_last, busy);
        end
        mq.delete();
        #8 reset = 1'b1;
        step("arst_release");
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_idle: observed ir=%b v=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_zero_vector();
        int lasts = 0;
        clear_log();
        out_ready = 1'b1;
        send('0, "zero_accept");
        for (int n = 0; n < 10 && mq.size() > 0; n++) begin
            if (mq.size() == 1) lasts++;
            step("zero");
        end
        checks++;
        if (seen.size() != SIZE || seen.sum() != 0 || lasts != 1) begin
            errors++;
            $display("FAIL zero_vector: observed %0d beats %p, required %0d beats of 00", seen.size(), seen, SIZE);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            in_vec    = {$urandom(), $urandom()};
            step("random");
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("random_drain");
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_vec = '0;
        test_reset();
        test_basic_drain();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_zero_vector();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vsm_drain.md
Name: vsm_drain

Overview:
- Reader side of the `vsm` output bus: captures one `8*SIZE`-bit result vector from `vsm.out` and replays it as a stream of 8-bit elements over a valid/ready handshake.
- Sits between the `vsm` array and the narrow activation/writeback path.
- Supports back-to-back vectors with zero bubble cycles, plus a synchronous flush.

Parameters:
- SIZE, 6, number of 8-bit elements per vector; must be ≥ 2.
- IW, `$clog2(SIZE)`, width of the element index (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- flush  input  1  synchronous abort of the vector in progress.
- in_valid  input  1  `in_vec` holds a result vector.
- in_ready  output  1  block can accept a vector this cycle.
- in_vec  input  8*SIZE  result vector; element k = `in_vec[8k+7:8k]`.
- out_valid  output  1  `out_data` is valid.
- out_ready  input  1  downstream accepts `out_data` this cycle.
- out_data  output  8  current element.
- out_index  output  IW  index k of the current element.
- out_last  output  1  current element is k = SIZE-1.
- busy  output  1  a vector is held (state SEND).

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE, buffer = 0, idx = 0.
  - out_valid = 0, out_data = 0, out_index = 0, out_last = 0, busy = 0.
  - in_ready is 1, but no transfer is taken while reset is asserted.
- Transfers: input transfer = in_valid & in_ready at a rising edge; output transfer = out_valid & out_ready at a rising edge.
- States:
  - IDLE: in_ready = 1, out_valid = 0. On an input transfer: buffer ← in_vec, idx ← 0, go to SEND.
  - SEND: out_valid = 1, out_data = buffer[8·idx +: 8], out_index = idx, out_last = (idx == SIZE-1), busy = 1.
    - Output transfer with idx < SIZE-1: idx increments.
    - Output transfer with idx = SIZE-1 and no input transfer: go to IDLE, idx ← 0.
    - Output transfer with idx = SIZE-1 and an input transfer in the same cycle: buffer reloads, idx ← 0, stay in SEND. There is no bubble cycle.
- in_ready = (state == IDLE) | (state == SEND & idx == SIZE-1 & out_ready & !flush). This is combinational from out_ready by design.
- Latency: a vector accepted at edge N presents element 0 on out_valid/out_data in the cycle after edge N. Steady-state throughput is one element per cycle when out_ready = 1.
- Element order: element 0 (LSB byte) first, up to element SIZE-1. Data passes through unmodified; no arithmetic.
- Backpressure: with out_ready = 0, out_data, out_index, out_last and out_valid hold stable. out_valid never drops without an output transfer, except on flush or reset.
- flush = 1 (synchronous, highest priority after reset):
  - At the next edge: state ← IDLE, idx ← 0, out_valid ← 0.
  - Buffer contents are don't-care. Any output or input transfer in that cycle is ignored.
  - in_ready is forced low during flush unless state is IDLE; in IDLE, flush and accept in the same cycle gives flush priority (no capture).
- Reset mid-vector: outputs go to their reset values immediately; the remaining elements are lost.
- in_vec is sampled only on an input transfer; changes at any other time have no effect.

Test Plan:
- Reset then basic drain:
  - Stimulus: in_vec = 48'h010203040506, out_ready held 1.
  - Response: out_data sequence 06,05,04,03,02,01 on 6 consecutive cycles; out_index 0..5; out_last only on 01; then out_valid = 0 and in_ready = 1.
- Backpressure:
  - Stimulus: in_vec = 48'hA1B2C3D4E5F6; drop out_ready for 3 cycles at index 2.
  - Response: out_data holds D4 and out_index holds 2 across the stall; the full sequence F6,E5,D4,C3,B2,A1 completes with no duplicate or missing element.
- Back-to-back:
  - Stimulus: 48'h123456789ABC followed by 48'hFEDCBA987654, in_valid held high, out_ready = 1.
  - Response: 12 consecutive valid cycles, BC..12 then 54..FE; in_ready pulses exactly on the out_last cycle; no bubble.
- Flush:
  - Stimulus: vector 48'h112233445566; assert flush at out_index 3.
  - Response: next cycle out_valid = 0, state IDLE; a new vector 48'hAABBCCDDEEFF then drains FF..AA starting at index 0.
- Async reset mid-stream:
  - Stimulus: vector 48'hFFFFFFFFFFFF; pull reset low between edges at index 4.
  - Response: out_valid, out_data, out_index and out_last go to 0 immediately, without waiting for a clock edge; after release, in_ready = 1 and out_valid = 0.
- Zero vector:
  - Stimulus: in_vec = 0.
  - Response: six beats of 00 with out_valid = 1; out_last on the 6th beat only.
